eclair_sdiv_26s_10ns_16s: RTL and testbench

Sequential signed divider that inverts the model's unsigned-10 × signed-16 → signed-26 product path. It divides a 26-bit signed dividend by a 10-bit unsigned divisor and returns a saturated 16-bit signed quotient. It is used in the function-tracking datapath wherever a scaled product must be normalised back to the 16-bit activation format. It computes one quotient bit per cycle with valid/ready handshakes on both sides.

---
 rtl/eclair_sdiv_26s_10ns_16s.sv | 152 +++++++++++++++
 tb/tb_eclair_sdiv_26s_10ns_16s.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/eclair_sdiv_26s_10ns_16s.sv
// rtl/eclair_sdiv_26s_10ns_16s.sv - restoring signed/unsigned divider, one quotient bit per cycle
// Define ECLAIR_SDIV_REM_EN to drive the signed remainder on rem; otherwise rem is tied to zero.
module eclair_sdiv_26s_10ns_16s #(
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 16,
  parameter int rem_WIDTH  = 11
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [rem_WIDTH-1:0]  rem,
  output logic                  ovf,
  output logic                  dz
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam int QMAX = (1 << (dout_WIDTH - 1)) - 1;

  state_t                  state_q;
  state_t                  state_d;
  logic [din0_WIDTH-1:0]   dvd;
  logic [din1_WIDTH-1:0]   dvs;
  logic [rem_WIDTH-1:0]    prem;
  logic                    neg;
  logic [4:0]              cnt;
  logic [dout_WIDTH-1:0]   dout_q;
  logic                    ovf_q;
  logic                    dz_q;

  logic [rem_WIDTH-1:0]    shifted;
  logic [rem_WIDTH:0]      diff;
  logic                    nonneg;
  logic                    pos_big;
  logic                    neg_big;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (cnt == 5'd0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Only the low bits of the shifted remainder are kept; the shifted-out carry
  // (prem msb) alone guarantees the trial subtraction succeeds.
  always_comb begin
    shifted = {prem[rem_WIDTH-2:0], dvd[din0_WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    nonneg  = prem[rem_WIDTH-1] | ~diff[rem_WIDTH];
    pos_big = (dvd > din0_WIDTH'(QMAX));
    neg_big = (dvd > din0_WIDTH'(QMAX + 1));
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd  <= din0[din0_WIDTH-1] ? (~din0 + din0_WIDTH'(1)) : din0;
            dvs  <= din1;
            neg  <= din0[din0_WIDTH-1];
            prem <= '0;
            cnt  <= 5'(din0_WIDTH - 1);
          end
        end
        CALC: begin
          dvd  <= {dvd[din0_WIDTH-2:0], nonneg};
          prem <= nonneg ? diff[rem_WIDTH-1:0] : shifted;
          cnt  <= cnt - 5'd1;
        end
        FIX: begin
          dz_q <= (dvs == '0);
          if (dvs == '0) begin
            dout_q <= neg ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
            ovf_q  <= 1'b0;
          end else if (!neg && pos_big) begin
            dout_q <= {1'b0, {(dout_WIDTH-1){1'b1}}};
            ovf_q  <= 1'b1;
          end else if (neg && neg_big) begin
            dout_q <= {1'b1, {(dout_WIDTH-1){1'b0}}};
            ovf_q  <= 1'b1;
          end else begin
            dout_q <= neg ? (~dvd[dout_WIDTH-1:0] + dout_WIDTH'(1)) : dvd[dout_WIDTH-1:0];
            ovf_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = dout_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

`ifdef ECLAIR_SDIV_REM_EN
  logic [rem_WIDTH-1:0] rem_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rem_q <= '0;
    end else if (state_q == FIX) begin
      if (dvs == '0) begin
        rem_q <= '0;
      end else begin
        rem_q <= neg ? (~prem + rem_WIDTH'(1)) : prem;
      end
    end
  end

  assign rem = rem_q;
`else
  assign rem = '0;
`endif

endmodule

// File: tb/tb_eclair_sdiv_26s_10ns_16s.sv
// tb/tb_eclair_sdiv_26s_10ns_16s.sv - directed self-checking bench with arithmetic reference model
module tb_eclair_sdiv_26s_10ns_16s;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] din0 = '0;
  logic [9:0]  din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] dout;
  logic [10:0] rem;
  logic        ovf;
  logic        dz;

  typedef struct packed {
    logic [15:0] d;
    logic [10:0] r;
    logic        o;
    logic        z;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  eclair_sdiv_26s_10ns_16s dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .rem       (rem),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Reference: plain integer division (truncating, remainder follows dividend) then saturation.
  function automatic exp_t model(input longint a, input longint b);
    exp_t   e;
    longint q;
    longint r;
    e = '0;
    if (b == 0) begin
      e.z = 1'b1;
      e.d = (a >= 0) ? 16'h7fff : 16'h8000;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 32767) begin
        e.d = 16'h7fff;
        e.o = 1'b1;
      end else if (q < -32768) begin
        e.d = 16'h8000;
        e.o = 1'b1;
      end else begin
        e.d = q[15:0];
      end
`ifdef ECLAIR_SDIV_REM_EN
      e.r = r[10:0];
`endif
    end
    return e;
  endfunction

  always @(negedge ap_clk) begin
    if (!ap_rst && out_valid) begin
      if (expq.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("dout", $signed(dout), $signed(expq[0].d));
        check("rem",  $signed(rem),  $signed(expq[0].r));
        check("ovf",  ovf, expq[0].o);
        check("dz",   dz,  expq[0].z);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic run_op(input longint a, input longint b, input logic [15:0] ld,
                        input logic [10:0] lr, input logic lo, input logic lz, input bit bp);
    exp_t e;
    int   n;
    bit   seen;
    e = model(a, b);
    check("model_dout", $signed(e.d), $signed(ld));
`ifdef ECLAIR_SDIV_REM_EN
    check("model_rem", $signed(e.r), $signed(lr));
`endif
    check("model_ovf", e.o, lo);
    check("model_dz", e.z, lz);
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    out_ready = !bp;
    din0 = a[25:0];
    din1 = b[9:0];
    in_valid = 1'b1;
    @(posedge ap_clk);
    expq.push_back(e);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      check("busy_in_ready", in_ready, 0);
      din0 = 26'($urandom);
      din1 = 10'($urandom);
      @(posedge ap_clk);
      #1;
      n++;
      seen = out_valid;
    end
    check("latency", n, 27);
    if (bp) begin
      repeat (10) begin
        in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge ap_clk);
    #1;
    check("released_out_valid", out_valid, 0);
    check("released_in_ready", in_ready, 1);
    out_ready = 1'b1;
  endtask

  initial begin
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_rem", rem, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dz", dz, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    run_op(1000,      10,   16'd100,  11'd0,   1'b0, 1'b0, 1'b0);
    run_op(-1001,     10,   16'hff9c, 11'h7ff, 1'b0, 1'b0, 1'b0);
    run_op(-32768000, 1000, 16'h8000, 11'd0,   1'b0, 1'b0, 1'b0);
    run_op(33554431,  1,    16'h7fff, 11'd0,   1'b1, 1'b0, 1'b0);
    run_op(-33554432, 1023, 16'h8000, 11'h7e0, 1'b1, 1'b0, 1'b0);
    run_op(5,         0,    16'h7fff, 11'd0,   1'b0, 1'b1, 1'b0);
    run_op(-5,        0,    16'h8000, 11'd0,   1'b0, 1'b1, 1'b0);
    run_op(123456,    789,  16'd156,  11'd372, 1'b0, 1'b0, 1'b1);

    // Abort an operation part way through CALC.
    din0 = 26'd1000;
    din1 = 10'd3;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge ap_clk);
    #2;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    run_op(7, 2, 16'd3, 11'd1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge ap_clk);
    #1;
    check("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
